// File: rtl/clock_manager.sv
// Post-PLL clock manager: qualifies PLL lock into a clean system reset and generates
// NUM_CH phase-accumulator tick enables. Define CLOCK_MANAGER_LOSS_COUNT_EN for lost_count.
module clock_manager #(
  parameter int NUM_CH            = 2,
  parameter int ACC_WIDTH         = 24,
  parameter int SYNC_STAGES       = 2,
  parameter int STABLE_CYCLES     = 1024,
  parameter int RESET_HOLD_CYCLES = 16
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        pll_locked,
  input  logic [NUM_CH*ACC_WIDTH-1:0] phase_inc,
  input  logic [NUM_CH-1:0]           tick_enable,
  input  logic                        clear_lost,
  output logic                        sys_reset_n,
  output logic                        ready,
  output logic                        lock_lost,
  output logic [NUM_CH-1:0]           tick
`ifdef CLOCK_MANAGER_LOSS_COUNT_EN
  ,
  output logic [7:0]                  lost_count
`endif
);

  localparam int CNT_MAX = (STABLE_CYCLES > RESET_HOLD_CYCLES) ? STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Gray-ordered so every legal transition flips a single bit
  typedef enum logic [1:0] {
    S_WAIT = 2'b00,
    S_STAB = 2'b01,
    S_RUN  = 2'b11,
    S_HOLD = 2'b10
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_lock_s;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   r_run;
  logic                   r_lock_lost;
  logic                   w_run_nxt;
  logic                   w_run_stay;
  logic                   w_loss;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign w_lock_s = r_sync[SYNC_STAGES-1];

  // State register plus the registered run/lost flags derived from the next state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_WAIT;
      r_cnt       <= '0;
      r_run       <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_run   <= w_run_nxt;
      if (w_loss) begin
        r_lock_lost <= 1'b1;
      end else if (clear_lost) begin
        r_lock_lost <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_WAIT: begin
        w_cnt_nxt = '0;
        if (w_lock_s) w_state_nxt = S_STAB;
      end
      S_STAB: begin
        if (!w_lock_s) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_RUN: begin
        w_cnt_nxt = '0;
        if (!w_lock_s) w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        // Hold time runs regardless of lock so a flapping PLL cannot shorten it
        if (r_cnt == CNT_W'(RESET_HOLD_CYCLES - 1)) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_run_nxt  = (w_state_nxt == S_RUN);
    w_run_stay = (r_state == S_RUN) && w_run_nxt;
    w_loss     = (r_state == S_RUN) && (w_state_nxt == S_HOLD);
  end

  assign sys_reset_n = r_run;
  assign ready       = r_run;
  assign lock_lost   = r_lock_lost;

`ifdef CLOCK_MANAGER_LOSS_COUNT_EN
  logic [7:0] r_lost_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_lost_count <= 8'd0;
    end else if (w_loss && (r_lost_count != 8'hFF)) begin
      r_lost_count <= r_lost_count + 8'd1;
    end
  end

  assign lost_count = r_lost_count;
`endif

  // Accumulators only run while staying in RUN, so entering or leaving RUN clears them
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_tick;
    logic [ACC_WIDTH:0]   w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, phase_inc[g*ACC_WIDTH +: ACC_WIDTH]};

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_acc  <= '0;
        r_tick <= 1'b0;
      end else if (w_run_stay && tick_enable[g]) begin
        r_acc  <= w_sum[ACC_WIDTH-1:0];
        r_tick <= w_sum[ACC_WIDTH];
      end else begin
        r_acc  <= '0;
        r_tick <= 1'b0;
      end
    end

    assign tick[g] = r_tick;
  end

endmodule

// File: tb/tb_clock_manager.sv
// Scoreboard bench for clock_manager: expectations are queued with a due cycle and
// compared by a negedge monitor. Define CLOCK_MANAGER_LOSS_COUNT_EN to cover lost_count.
module tb_clock_manager;

  localparam int NUM_CH = 2;
  localparam int ACC_W  = 8;
  localparam int SYNC   = 2;
  localparam int STABLE = 16;
  localparam int HOLD   = 16;

  localparam int SEL_SRN  = 0;
  localparam int SEL_RDY  = 1;
  localparam int SEL_LL   = 2;
  localparam int SEL_TICK = 3;
  localparam int SEL_CNT  = 4;

  logic                    clock = 1'b0;
  bit                      clk_run = 1'b1;
  logic                    reset_n = 1'b0;
  logic                    pll_locked = 1'b0;
  logic                    clear_lost = 1'b0;
  logic [NUM_CH*ACC_W-1:0] phase_inc = '0;
  logic [NUM_CH-1:0]       tick_enable = '0;
  logic                    sys_reset_n;
  logic                    ready;
  logic                    lock_lost;
  logic [NUM_CH-1:0]       tick;
`ifdef CLOCK_MANAGER_LOSS_COUNT_EN
  logic [7:0]              lost_count;
`endif

  int cyc   = 0;
  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int    due;
    int    sel;
    int    val;
    string nm;
  } exp_t;

  exp_t sb[$];

  clock_manager #(
    .NUM_CH(NUM_CH), .ACC_WIDTH(ACC_W), .SYNC_STAGES(SYNC),
    .STABLE_CYCLES(STABLE), .RESET_HOLD_CYCLES(HOLD)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .pll_locked(pll_locked),
    .phase_inc(phase_inc),
    .tick_enable(tick_enable),
    .clear_lost(clear_lost),
    .sys_reset_n(sys_reset_n),
    .ready(ready),
    .lock_lost(lock_lost),
    .tick(tick)
`ifdef CLOCK_MANAGER_LOSS_COUNT_EN
    ,
    .lost_count(lost_count)
`endif
  );

  always begin
    #5;
    if (clk_run) clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int sample(input int sel);
    case (sel)
      SEL_SRN:  return int'(sys_reset_n);
      SEL_RDY:  return int'(ready);
      SEL_LL:   return int'(lock_lost);
      SEL_TICK: return int'(tick);
`ifdef CLOCK_MANAGER_LOSS_COUNT_EN
      SEL_CNT:  return int'(lost_count);
`endif
      default:  return -1;
    endcase
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic expect_at(input int due, input int sel, input int val, input string nm);
    exp_t e;
    e.due = due;
    e.sel = sel;
    e.val = val;
    e.nm  = nm;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic set_inc(input int ch, input int val);
    phase_inc[ch*ACC_W +: ACC_W] = ACC_W'(val);
  endtask

  // Monitor: compare every queued expectation that falls due on this cycle
  always @(negedge clock) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due <= cyc) begin
        if (sb[i].due < cyc) begin
          n_vec++;
          n_bad++;
          $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)",
                   sb[i].nm, sb[i].due, cyc);
        end else begin
          check(sb[i].nm, sample(sb[i].sel), sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int ph1[8];
    int ph2[8];
    ph1 = '{0, 0, 2, 1, 0, 2, 0, 3};
    ph2 = '{0, 0, 0, 0, 0, 0, 0, 1};

    // Reset state, then qualification with lock present from release
    step(2);
    t = cyc;
    expect_at(t, SEL_SRN, 0, "rst_sys_reset_n");
    expect_at(t, SEL_RDY, 0, "rst_ready");
    expect_at(t, SEL_LL, 0, "rst_lock_lost");
    expect_at(t, SEL_TICK, 0, "rst_tick");
`ifdef CLOCK_MANAGER_LOSS_COUNT_EN
    expect_at(t, SEL_CNT, 0, "rst_lost_count");
`endif
    reset_n    = 1'b1;
    pll_locked = 1'b1;
    expect_at(t + 18, SEL_SRN, 0, "qual_srn_edge18");
    expect_at(t + 18, SEL_TICK, 0, "qual_tick_edge18");
    expect_at(t + 19, SEL_SRN, 1, "qual_srn_edge19");
    expect_at(t + 19, SEL_RDY, 1, "qual_ready_edge19");
    step(24);

    // Lock loss in RUN, relock after 2 cycles, hold then requalify
    t = cyc;
    pll_locked = 1'b0;
    expect_at(t + 2, SEL_SRN, 1, "loss_srn_edge2");
    expect_at(t + 3, SEL_SRN, 0, "loss_srn_edge3");
    expect_at(t + 3, SEL_RDY, 0, "loss_ready_edge3");
    expect_at(t + 3, SEL_LL, 1, "loss_lock_lost");
    expect_at(t + 18, SEL_SRN, 0, "hold_srn");
    expect_at(t + 35, SEL_SRN, 0, "requal_srn_early");
    expect_at(t + 36, SEL_SRN, 1, "requal_srn");
    expect_at(t + 36, SEL_LL, 1, "lock_lost_sticky");
    step(2);
    pll_locked = 1'b1;
    step(38);

    // clear_lost pulse
    t = cyc;
    clear_lost = 1'b1;
    expect_at(t, SEL_LL, 1, "ll_before_clear");
    expect_at(t + 1, SEL_LL, 0, "ll_cleared");
    step(1);
    clear_lost = 1'b0;
    step(3);

    // clear_lost coincident with a new loss: set wins
    t = cyc;
    pll_locked = 1'b0;
    expect_at(t + 2, SEL_LL, 0, "ll_clear_before_loss");
    expect_at(t + 3, SEL_LL, 1, "ll_set_wins");
    expect_at(t + 4, SEL_LL, 1, "ll_set_wins_held");
    expect_at(t + 3, SEL_SRN, 0, "loss2_srn");
    expect_at(t + 35, SEL_SRN, 0, "requal2_srn_early");
    expect_at(t + 36, SEL_SRN, 1, "requal2_srn");
    step(2);
    clear_lost = 1'b1;
    step(1);
    clear_lost = 1'b0;
    pll_locked = 1'b1;
    step(37);

    // Tick channels: inc 64 / 96, then inc 0, disable/re-enable, then exit from RUN
    t = cyc;
    set_inc(0, 64);
    set_inc(1, 96);
    tick_enable = 2'b11;
    for (int i = 0; i < 8; i++) expect_at(t + 1 + i, SEL_TICK, ph1[i], "tick_64_96");
    for (int i = 0; i < 8; i++) expect_at(t + 9 + i, SEL_TICK, ph2[i], "tick_inc0_reen");
    expect_at(t + 17, SEL_TICK, 0, "tick_255_first");
    expect_at(t + 18, SEL_TICK, 1, "tick_255_a");
    expect_at(t + 20, SEL_TICK, 1, "tick_255_b");
    expect_at(t + 20, SEL_RDY, 1, "exit_ready_before");
    expect_at(t + 21, SEL_TICK, 0, "exit_tick_cleared");
    expect_at(t + 21, SEL_RDY, 0, "exit_ready_low");
    expect_at(t + 54, SEL_SRN, 1, "requal3_srn");
    expect_at(t + 55, SEL_TICK, 0, "rerun_tick_first");
    expect_at(t + 56, SEL_TICK, 1, "rerun_tick_carry");
    step(8);
    set_inc(1, 0);
    step(2);
    tick_enable = 2'b10;
    step(2);
    tick_enable = 2'b11;
    step(4);
    set_inc(0, 255);
    step(2);
    pll_locked = 1'b0;
    step(3);
    pll_locked = 1'b1;
    step(36);

    // Stop the clock mid-RUN and assert reset asynchronously
    clk_run = 1'b0;
    #2;
    check("pre_arst_tick", int'(tick), 1);
    check("pre_arst_srn", int'(sys_reset_n), 1);
    check("pre_arst_ll", int'(lock_lost), 1);
`ifdef CLOCK_MANAGER_LOSS_COUNT_EN
    check("lost_count_3", int'(lost_count), 3);
`endif
    reset_n = 1'b0;
    #1;
    check("arst_srn", int'(sys_reset_n), 0);
    check("arst_ready", int'(ready), 0);
    check("arst_ll", int'(lock_lost), 0);
    check("arst_tick", int'(tick), 0);
`ifdef CLOCK_MANAGER_LOSS_COUNT_EN
    check("arst_lost_count", int'(lost_count), 0);
`endif
    pll_locked = 1'b0;
    clk_run    = 1'b1;
    step(2);

    // 3-cycle lock glitch at STABILIZE cnt=10 restarts qualification
    t = cyc;
    pll_locked = 1'b1;
    reset_n    = 1'b1;
    expect_at(t + 19, SEL_SRN, 0, "glitch_no_early_run");
    expect_at(t + 34, SEL_SRN, 0, "glitch_srn_early");
    expect_at(t + 35, SEL_SRN, 1, "glitch_srn_release");
    expect_at(t + 35, SEL_RDY, 1, "glitch_ready_release");
    step(13);
    pll_locked = 1'b0;
    step(3);
    pll_locked = 1'b1;
    step(22);

`ifdef CLOCK_MANAGER_LOSS_COUNT_EN
    // 300 losses: count saturates at 255
    for (int i = 0; i < 300; i++) begin
      pll_locked = 1'b0;
      step(3);
      pll_locked = 1'b1;
      step(37);
      if (i == 253) expect_at(cyc, SEL_CNT, 254, "lost_count_254");
    end
    expect_at(cyc, SEL_CNT, 255, "lost_count_sat");
    expect_at(cyc, SEL_SRN, 1, "sat_back_in_run");
`endif

    for (int i = 0; i < 20 && sb.size() > 0; i++) step(1);
    if (sb.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/clock_manager.md
Name: clock_manager

Overview:
Post-PLL clock management block. Qualifies the PLL lock indication and generates a clean system reset that is released only after lock has been stable for a programmable time. Generates NUM_CH independent clock-enable tick streams from phase accumulators. Sits directly after the PLL wrapper and feeds system reset and baud/sample enables to the rest of the design.

Parameters:
NUM_CH, 2, number of tick channels (1..8)
ACC_WIDTH, 24, phase accumulator width per channel
SYNC_STAGES, 2, synchroniser depth for pll_locked (>=2)
STABLE_CYCLES, 1024, consecutive synchronised-lock cycles required before reset release (>=1)
RESET_HOLD_CYCLES, 16, minimum cycles sys_reset_n stays low after a lock loss (>=1)

Ports:
clock  in  1  system clock (PLL output)
reset_n  in  1  asynchronous, active-low reset
pll_locked  in  1  raw PLL lock, asynchronous to clock
phase_inc  in  NUM_CH*ACC_WIDTH  per-channel increment; channel i at [i*ACC_WIDTH +: ACC_WIDTH]
tick_enable  in  NUM_CH  per-channel enable
clear_lost  in  1  clears lock_lost
sys_reset_n  out  1  qualified system reset, active-low, registered
ready  out  1  high in RUN state, registered
lock_lost  out  1  sticky lock-loss flag
tick  out  NUM_CH  one-cycle clock-enable strobes, registered
lost_count  out  8  lock-loss event count (only with macro)

Behaviour:
- Async reset: state=WAIT_LOCK; sync flops, counters, accumulators=0; sys_reset_n=0, ready=0, lock_lost=0, tick=0, lost_count=0. Takes effect immediately, no clock required.
- pll_locked passes through SYNC_STAGES flops -> lock_s.
- FSM (single state register; sys_reset_n and ready decoded from registered state, both high only in RUN):
  - WAIT_LOCK: cnt=0; lock_s=1 -> STABILIZE.
  - STABILIZE: cnt increments each cycle; lock_s=0 -> WAIT_LOCK with cnt cleared; cnt==STABLE_CYCLES-1 with lock_s=1 -> RUN.
  - RUN: lock_s=0 -> HOLD, cnt=0, set lock_lost.
  - HOLD: counts RESET_HOLD_CYCLES cycles irrespective of lock_s, then -> WAIT_LOCK.
- Latency: lock_s high at edge SYNC_STAGES after pll_locked rises; STABILIZE one edge later; RUN (sys_reset_n=1) after a further STABLE_CYCLES edges. Loss: sys_reset_n low SYNC_STAGES+1 edges after pll_locked falls.
- Tick channel i: acc_i is ACC_WIDTH bits; each cycle with state==RUN and tick_enable[i]=1: {carry, acc_i} <= acc_i + inc_i; tick[i] <= carry. Otherwise acc_i<=0, tick[i]<=0. Tick rate = f_clock*inc/2^ACC_WIDTH. inc=0 never ticks. A phase_inc change applies on the next add without clearing acc.
- Leaving RUN clears all accumulators and ticks on the same edge that ready falls.
- lock_lost: set on RUN->HOLD; cleared by clear_lost; set wins on the same cycle.
- pll_locked glitches shorter than one clock may or may not be seen; any seen low restarts qualification.

Optional Feature:
Macro CLOCK_MANAGER_LOSS_COUNT_EN. With it: lost_count port exists; 8-bit counter increments on every RUN->HOLD transition and saturates at 255; cleared only by reset_n. Without it: port and counter are absent; all other behaviour is identical.

Test Plan:
- SYNC_STAGES=2, STABLE_CYCLES=16, pll_locked=1 from reset release -> sys_reset_n and ready rise exactly on edge 19 after release; tick=0 before that.
- Lock established, pll_locked low for 3 cycles at STABILIZE cnt=10 -> returns to WAIT_LOCK; sys_reset_n stays 0; release occurs 16+ cycles after lock_s returns.
- In RUN, drop pll_locked permanently -> sys_reset_n=0 at edge 3, lock_lost=1; then re-assert after 2 cycles -> sys_reset_n held low >= RESET_HOLD_CYCLES, then re-qualifies; clear_lost pulse -> lock_lost=0; clear_lost coincident with a new loss -> lock_lost stays 1.
- ACC_WIDTH=8, RUN: inc=64 -> tick every 4th cycle; inc=96 -> exactly 3 ticks per 8 cycles; inc=0 -> none; tick_enable=0 -> none and acc cleared (first tick after re-enable at cycle 4 for inc=64).
- Assert reset_n mid-RUN with clock stopped -> all outputs 0 immediately.
- With CLOCK_MANAGER_LOSS_COUNT_EN: 3 lock losses -> lost_count=3; 300 losses -> 255.
